// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
//   Receives PS/2 keyboard frames and removes the E0/F0/E1 prefixes. Each make
//   or break code produces one scan_received pulse. At that pulse scan,
//   extended and released are valid, and they hold until the next pulse.
//
//   Processing order:
//     1. The raw pins are synchronised.
//     2. The PS/2 clock is glitch-filtered.
//     3. The 11-bit frame is deserialised and its parity and stop bit are checked.
//     4. Prefix bytes and protocol bytes (BAT, ACK, echo, resend, error,
//        overrun) are decoded.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   ps2clk         raw PS/2 clock pin (asynchronous)
//   ps2data        raw PS/2 data pin (asynchronous)
//   scan_received  one-cycle pulse, new scan/extended/released valid
//   scan           scancode with prefixes removed
//   extended       code was preceded by E0
//   released       code was preceded by F0
//   frame_error    one-cycle pulse on bad start/parity/stop bit or timeout
//
// Receiver states
//   state      | meaning
//   RX_IDLE    | waiting for a start bit
//   RX_DATA    | shifting in 8 data bits, LSB first
//   RX_PARITY  | sampling the odd-parity bit
//   RX_STOP    | sampling the stop bit, then reporting the byte or an error
module ps2_scancode_decoder #(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 56000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2clk,
   input  logic       ps2data,
   output logic       scan_received,
   output logic [7:0] scan,
   output logic       extended,
   output logic       released,
   output logic       frame_error
);

   typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

   localparam logic [3:0]  FLT_LAST = 4'(FILTER_LEN - 1);
   localparam logic [15:0] TO_LOAD  = 16'(TIMEOUT - 1);

   logic [1:0]  clk_sync, data_sync;
   logic        clk_s, data_s;
   logic        clk_filt;
   logic [3:0]  flt_cnt;
   logic        fe;

   rx_state_t   state;
   logic [2:0]  bitcnt;
   logic [7:0]  shreg;
   logic        parity_bit;
   logic [15:0] to_cnt;
   logic        to_expired;
   logic        byte_valid;
   logic        timeout_hit;

   logic        ext, rel;
   logic [2:0]  skip;

   assign clk_s  = clk_sync[1];
   assign data_s = data_sync[1];

   // Synchronisers reset to the idle-high line level so that leaving reset
   // never produces a spurious edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
      end else begin
         clk_sync  <= {clk_sync[0], ps2clk};
         data_sync <= {data_sync[0], ps2data};
      end
   end

   // The filtered clock follows the synchronised clock only after FILTER_LEN
   // consecutive samples that disagree with it. fe is produced on the same
   // edge that moves the filtered clock from high to low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_filt <= 1'b1;
         flt_cnt  <= '0;
         fe       <= 1'b0;
      end else begin
         fe <= 1'b0;
         if (clk_s == clk_filt) begin
            flt_cnt <= '0;
         end else if (flt_cnt == FLT_LAST) begin
            clk_filt <= clk_s;
            flt_cnt  <= '0;
            fe       <= clk_filt & ~clk_s;
         end else begin
            flt_cnt <= flt_cnt + 4'd1;
         end
      end
   end

   // Down-counting frame watchdog: it reloads on every falling edge and
   // whenever the receiver is idle, and it expires at terminal count zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         to_cnt <= '0;
      else if (state == RX_IDLE || fe)
         to_cnt <= TO_LOAD;
      else if (to_cnt != 16'd0)
         to_cnt <= to_cnt - 16'd1;
   end

   assign to_expired = (state != RX_IDLE) && !fe && (to_cnt == 16'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= RX_IDLE;
         bitcnt      <= '0;
         shreg       <= '0;
         parity_bit  <= 1'b0;
         byte_valid  <= 1'b0;
         frame_error <= 1'b0;
         timeout_hit <= 1'b0;
      end else begin
         byte_valid  <= 1'b0;
         frame_error <= 1'b0;
         timeout_hit <= 1'b0;
         if (to_expired) begin
            state       <= RX_IDLE;
            frame_error <= 1'b1;
            timeout_hit <= 1'b1;
         end else if (fe) begin
            case (state)
               RX_IDLE: begin
                  if (!data_s) begin
                     state  <= RX_DATA;
                     bitcnt <= '0;
                  end else begin
                     frame_error <= 1'b1;
                  end
               end
               RX_DATA: begin
                  shreg  <= {data_s, shreg[7:1]};
                  bitcnt <= bitcnt + 3'd1;
                  if (bitcnt == 3'd7)
                     state <= RX_PARITY;
               end
               RX_PARITY: begin
                  parity_bit <= data_s;
                  state      <= RX_STOP;
               end
               RX_STOP: begin
                  if (data_s && ((^shreg) ^ parity_bit))
                     byte_valid <= 1'b1;
                  else
                     frame_error <= 1'b1;
                  state <= RX_IDLE;
               end
               default: state <= RX_IDLE;
            endcase
         end
      end
   end

   // shreg is stable until the next frame's first data bit, so the decoder
   // reads it directly on the cycle after byte_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ext           <= 1'b0;
         rel           <= 1'b0;
         skip          <= '0;
         scan          <= '0;
         extended      <= 1'b0;
         released      <= 1'b0;
         scan_received <= 1'b0;
      end else begin
         scan_received <= 1'b0;
         if (timeout_hit) begin
            ext  <= 1'b0;
            rel  <= 1'b0;
            skip <= '0;
         end else if (byte_valid) begin
            if (skip != 3'd0) begin
               skip <= skip - 3'd1;
            end else begin
               case (shreg)
                  8'hE0: ext  <= 1'b1;
                  8'hF0: rel  <= 1'b1;
                  8'hE1: skip <= 3'd7;
                  8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF: begin
                     ext <= 1'b0;
                     rel <= 1'b0;
                  end
                  default: begin
                     scan          <= shreg;
                     extended      <= ext;
                     released      <= rel;
                     scan_received <= 1'b1;
                     ext           <= 1'b0;
                     rel           <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
module tb_ps2_scancode_decoder;

   localparam int FILTER_LEN = 8;
   localparam int TIMEOUT    = 400;
   localparam int H          = 20;   // half PS/2 bit period in clk cycles

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ps2clk = 1'b1;
   logic       ps2data = 1'b1;
   logic       scan_received;
   logic [7:0] scan;
   logic       extended;
   logic       released;
   logic       frame_error;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc = 0;
   int pulse_cnt = 0;
   int err_cnt = 0;
   int last_pulse_cyc = 0;
   int last_fall_cyc = 0;

   ps2_scancode_decoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .ps2clk(ps2clk), .ps2data(ps2data),
      .scan_received(scan_received), .scan(scan), .extended(extended),
      .released(released), .frame_error(frame_error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (scan_received) begin
         pulse_cnt++;
         last_pulse_cyc = cyc;
      end
      if (frame_error) err_cnt++;
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      ps2data = b;
      idle(H / 2);
      ps2clk = 1'b0;
      last_fall_cyc = cyc;
      idle(H);
      ps2clk = 1'b1;
      idle(H / 2);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic bad_parity);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit((~^d) ^ bad_parity);
      send_bit(1'b1);
      ps2data = 1'b1;
      idle(2 * H);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      idle(5);
      if (scan_received !== 1'b0) begin $display("FAIL reset_scan_received: got %b expected 0", scan_received); n_fail++; end
      n_checks++;
      if (scan !== 8'h00) begin $display("FAIL reset_scan: got %h expected 00", scan); n_fail++; end
      n_checks++;
      if (extended !== 1'b0) begin $display("FAIL reset_extended: got %b expected 0", extended); n_fail++; end
      n_checks++;
      if (released !== 1'b0) begin $display("FAIL reset_released: got %b expected 0", released); n_fail++; end
      n_checks++;
      if (frame_error !== 1'b0) begin $display("FAIL reset_frame_error: got %b expected 0", frame_error); n_fail++; end
      n_checks++;
      rst_n = 1'b1;
      idle(30);
      if (pulse_cnt != 0 || err_cnt != 0) begin $display("FAIL reset_idle_pulses: got %0d/%0d expected 0/0", pulse_cnt, err_cnt); n_fail++; end
      n_checks++;
   endtask

   task automatic test_single_frame;
      int p0, e0, lat;
      p0 = pulse_cnt; e0 = err_cnt;
      send_frame(8'h1C, 1'b0);
      lat = last_pulse_cyc - last_fall_cyc;
      if (pulse_cnt - p0 != 1) begin $display("FAIL single_pulses: got %0d expected 1", pulse_cnt - p0); n_fail++; end
      n_checks++;
      if (err_cnt != e0) begin $display("FAIL single_errors: got %0d expected 0", err_cnt - e0); n_fail++; end
      n_checks++;
      if (scan !== 8'h1C) begin $display("FAIL single_scan: got %h expected 1c", scan); n_fail++; end
      n_checks++;
      if (extended !== 1'b0 || released !== 1'b0) begin $display("FAIL single_flags: got ext=%b rel=%b expected 0 0", extended, released); n_fail++; end
      n_checks++;
      // pin fall -> 2 sync stages -> FILTER_LEN samples -> fe cycle -> byte_valid -> pulse
      if (lat != FILTER_LEN + 4) begin $display("FAIL single_latency: got %0d expected %0d", lat, FILTER_LEN + 4); n_fail++; end
      n_checks++;
   endtask

   task automatic test_prefixes;
      int p0;
      p0 = pulse_cnt;
      send_frame(8'hF0, 1'b0);
      send_frame(8'h1C, 1'b0);
      if (pulse_cnt - p0 != 1) begin $display("FAIL break_pulses: got %0d expected 1", pulse_cnt - p0); n_fail++; end
      n_checks++;
      if (scan !== 8'h1C || released !== 1'b1 || extended !== 1'b0) begin $display("FAIL break_code: got %h ext=%b rel=%b expected 1c 0 1", scan, extended, released); n_fail++; end
      n_checks++;
      p0 = pulse_cnt;
      send_frame(8'hE0, 1'b0);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h75, 1'b0);
      if (pulse_cnt - p0 != 1) begin $display("FAIL ext_break_pulses: got %0d expected 1", pulse_cnt - p0); n_fail++; end
      n_checks++;
      if (scan !== 8'h75 || extended !== 1'b1 || released !== 1'b1) begin $display("FAIL ext_break_code: got %h ext=%b rel=%b expected 75 1 1", scan, extended, released); n_fail++; end
      n_checks++;
      send_frame(8'h16, 1'b0);
      if (scan !== 8'h16 || extended !== 1'b0 || released !== 1'b0) begin $display("FAIL flags_cleared: got %h ext=%b rel=%b expected 16 0 0", scan, extended, released); n_fail++; end
      n_checks++;
   endtask

   task automatic test_parity_error;
      int p0, e0;
      p0 = pulse_cnt; e0 = err_cnt;
      send_frame(8'h1C, 1'b1);
      if (err_cnt - e0 != 1) begin $display("FAIL parity_errors: got %0d expected 1", err_cnt - e0); n_fail++; end
      n_checks++;
      if (pulse_cnt != p0) begin $display("FAIL parity_pulses: got %0d expected 0", pulse_cnt - p0); n_fail++; end
      n_checks++;
      if (scan !== 8'h16) begin $display("FAIL parity_scan_held: got %h expected 16", scan); n_fail++; end
      n_checks++;
   endtask

   task automatic test_timeout;
      int p0, e0;
      send_frame(8'hE0, 1'b0);          // pending prefix must be wiped by the timeout
      e0 = err_cnt; p0 = pulse_cnt;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      ps2data = 1'b1;
      idle(TIMEOUT + 10);
      if (err_cnt - e0 != 1) begin $display("FAIL timeout_errors: got %0d expected 1", err_cnt - e0); n_fail++; end
      n_checks++;
      send_frame(8'h29, 1'b0);
      if (pulse_cnt - p0 != 1) begin $display("FAIL timeout_recover_pulses: got %0d expected 1", pulse_cnt - p0); n_fail++; end
      n_checks++;
      if (scan !== 8'h29 || extended !== 1'b0) begin $display("FAIL timeout_recover_code: got %h ext=%b expected 29 0", scan, extended); n_fail++; end
      n_checks++;
   endtask

   task automatic test_pause;
      logic [7:0] seq [9];
      int p0, e0;
      seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h5A};
      p0 = pulse_cnt; e0 = err_cnt;
      for (int i = 0; i < 9; i++) send_frame(seq[i], 1'b0);
      if (pulse_cnt - p0 != 1) begin $display("FAIL pause_pulses: got %0d expected 1", pulse_cnt - p0); n_fail++; end
      n_checks++;
      if (scan !== 8'h5A || extended !== 1'b0 || released !== 1'b0) begin $display("FAIL pause_code: got %h ext=%b rel=%b expected 5a 0 0", scan, extended, released); n_fail++; end
      n_checks++;
      if (err_cnt != e0) begin $display("FAIL pause_errors: got %0d expected 0", err_cnt - e0); n_fail++; end
      n_checks++;
   endtask

   task automatic test_glitch;
      int p0, e0;
      p0 = pulse_cnt; e0 = err_cnt;
      for (int k = 0; k < 6; k++) begin
         ps2data = k[0];
         idle(5);
         ps2clk = 1'b0;
         idle(2);
         ps2clk = 1'b1;
         idle(12);
      end
      ps2data = 1'b1;
      idle(20);
      if (err_cnt != e0 || pulse_cnt != p0) begin $display("FAIL glitch_events: got err=%0d pulse=%0d expected 0 0", err_cnt - e0, pulse_cnt - p0); n_fail++; end
      n_checks++;
      send_frame(8'h1C, 1'b0);
      if (pulse_cnt - p0 != 1 || scan !== 8'h1C) begin $display("FAIL glitch_then_frame: got pulses=%0d scan=%h expected 1 1c", pulse_cnt - p0, scan); n_fail++; end
      n_checks++;
      if (err_cnt != e0) begin $display("FAIL glitch_frame_errors: got %0d expected 0", err_cnt - e0); n_fail++; end
      n_checks++;
   endtask

   task automatic test_reset_midframe;
      int p0;
      send_frame(8'h16, 1'b0);
      p0 = pulse_cnt;
      send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_bit(1'b0);
      rst_n = 1'b0;
      idle(4);
      rst_n = 1'b1;
      ps2data = 1'b1;
      idle(TIMEOUT + 10);
      if (scan !== 8'h00 || pulse_cnt != p0) begin $display("FAIL midreset_state: got scan=%h pulses=%0d expected 00 0", scan, pulse_cnt - p0); n_fail++; end
      n_checks++;
      send_frame(8'h1C, 1'b0);
      if (pulse_cnt - p0 != 1 || scan !== 8'h1C) begin $display("FAIL midreset_frame: got pulses=%0d scan=%h expected 1 1c", pulse_cnt - p0, scan); n_fail++; end
      n_checks++;
      send_frame(8'hAA, 1'b0);
      send_frame(8'hFA, 1'b0);
      if (pulse_cnt - p0 != 1 || scan !== 8'h1C) begin $display("FAIL dropped_bytes: got pulses=%0d scan=%h expected 1 1c", pulse_cnt - p0, scan); n_fail++; end
      n_checks++;
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_prefixes();
      test_parity_error();
      test_timeout();
      test_pause();
      test_glitch();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
